// File: rtl/cpstr_wrr_sched_if.sv
// cpstr_wrr_sched_if: scheduler bus (i_req/i_weight/i_done from the TX manager, o_grant/o_grant_idx/o_grant_valid back)
interface cpstr_wrr_sched_if #(
  parameter int NUM_STREAMS = 2,
  parameter int WEIGHT_W = 4
);
  localparam int IDX_W = NUM_STREAMS > 1 ? $clog2(NUM_STREAMS) : 1;
  logic [NUM_STREAMS-1:0] i_req;
  logic [WEIGHT_W*NUM_STREAMS-1:0] i_weight;
  logic i_done;
  logic [NUM_STREAMS-1:0] o_grant;
  logic [IDX_W-1:0] o_grant_idx;
  logic o_grant_valid;
  modport master (output i_req, i_weight, i_done, input o_grant, o_grant_idx, o_grant_valid);
  modport slave (input i_req, i_weight, i_done, output o_grant, o_grant_idx, o_grant_valid);
endinterface

// File: rtl/cpstr_wrr_sched.sv
// cpstr_wrr_sched: weighted round-robin burst scheduler; i_clk/i_rst (async high) plus bus (req/weight/done in, registered one-hot grant/idx/valid out)
module cpstr_wrr_sched #(
  parameter int NUM_STREAMS = 2,
  parameter int WEIGHT_W = 4
) (
  input logic i_clk,
  input logic i_rst,
  cpstr_wrr_sched_if.slave bus
);
  localparam int IDX_W = NUM_STREAMS > 1 ? $clog2(NUM_STREAMS) : 1;
  localparam int CW = IDX_W + 1;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  logic [0:0] state;
  logic [IDX_W-1:0] ptr;
  logic [WEIGHT_W-1:0] credit;
  logic [NUM_STREAMS-1:0] cand;
  logic [CW-1:0] pos;
  logic [IDX_W-1:0] sel;
  logic found;
  logic [WEIGHT_W-1:0] w_sel;
  logic [IDX_W-1:0] ptr_inc;
  always_comb begin
    cand = '0;
    for (int k = 0; k < NUM_STREAMS; k++)
      cand[k] = bus.i_req[k] && (bus.i_weight[k*WEIGHT_W +: WEIGHT_W] != '0);
    found = 1'b0;
    sel = '0;
    pos = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      pos = {1'b0, ptr} + CW'(i);
      pos = pos >= CW'(NUM_STREAMS) ? pos - CW'(NUM_STREAMS) : pos;
      if (!found && cand[pos[IDX_W-1:0]]) begin
        found = 1'b1;
        sel = pos[IDX_W-1:0];
      end
    end
    w_sel = bus.i_weight[sel*WEIGHT_W +: WEIGHT_W];
    ptr_inc = bus.o_grant_idx == IDX_W'(NUM_STREAMS-1) ? '0 : bus.o_grant_idx + IDX_W'(1);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
      ptr <= '0;
      credit <= '0;
      bus.o_grant <= '0;
      bus.o_grant_idx <= '0;
      bus.o_grant_valid <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (found) begin
        state <= ST_GRANT;
        bus.o_grant <= NUM_STREAMS'(1) << sel;
        bus.o_grant_idx <= sel;
        bus.o_grant_valid <= 1'b1;
        if (!(sel == ptr && credit != '0)) begin
          ptr <= sel;
          credit <= w_sel;
        end
      end
    end else if (bus.i_done) begin
      state <= ST_IDLE;
      bus.o_grant <= '0;
      bus.o_grant_valid <= 1'b0;
      credit <= credit - WEIGHT_W'(1);
      if (credit == WEIGHT_W'(1)) ptr <= ptr_inc;
    end
  end
endmodule

// File: tb/tb_cpstr_wrr_sched.sv
// tb_cpstr_wrr_sched: table vectors, hand sequences and random traffic against a behavioural WRR model
module tb_cpstr_wrr_sched;
  localparam int N = 3;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  cpstr_wrr_sched_if #(.NUM_STREAMS(N), .WEIGHT_W(W)) bus();
  cpstr_wrr_sched #(.NUM_STREAMS(N), .WEIGHT_W(W)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  typedef struct {
    bit rst;
    logic [N-1:0] req;
    logic [W*N-1:0] w;
    bit done;
    bit ev;
    int ei;
  } vec_t;
  vec_t vecs[$];
  int passed = 0;
  int total = 0;
  int m_ptr, m_credit, m_idx;
  bit m_valid;
  task automatic check(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  function automatic int wt(int k);
    return int'((bus.i_weight >> (k*W)) & 12'hF);
  endfunction
  task automatic model_reset();
    m_ptr = 0; m_credit = 0; m_idx = 0; m_valid = 0;
  endtask
  task automatic model_edge();
    if (!m_valid) begin
      int pick = -1;
      for (int k = 0; k < N; k++) begin
        int j = (m_ptr + k) % N;
        if (pick < 0 && bus.i_req[j] && wt(j) != 0) pick = j;
      end
      if (pick >= 0) begin
        if (!(pick == m_ptr && m_credit != 0)) begin
          m_ptr = pick;
          m_credit = wt(pick);
        end
        m_valid = 1;
        m_idx = pick;
      end
    end else if (bus.i_done) begin
      m_credit--;
      m_valid = 0;
      if (m_credit == 0) m_ptr = (m_idx + 1) % N;
    end
  endtask
  task automatic compare_model(string tag);
    check({tag, " valid"}, bus.o_grant_valid, m_valid);
    check({tag, " grant"}, bus.o_grant, m_valid ? (1 << m_idx) : 0);
    if (m_valid) check({tag, " idx"}, bus.o_grant_idx, m_idx);
  endtask
  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model(tag);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check("reset valid", bus.o_grant_valid, 0);
    check("reset grant", bus.o_grant, 0);
    check("reset idx", bus.o_grant_idx, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic add_seq(logic [N-1:0] req, logic [W*N-1:0] w, bit first_rst, int seq[8], int n);
    vec_t v;
    for (int j = 0; j < n; j++) begin
      v.rst = first_rst && j == 0; v.req = req; v.w = w; v.done = 0; v.ev = 1; v.ei = seq[j];
      vecs.push_back(v);
      v.rst = 0; v.done = 1; v.ev = 0; v.ei = 0;
      vecs.push_back(v);
    end
  endtask
  initial begin
    int es[5] = '{1, 0, 0, 0, 1};
    int hold_idx;
    rst = 1'b1;
    bus.i_req = '0;
    bus.i_weight = '0;
    bus.i_done = 1'b0;
    model_reset();
    add_seq(3'b011, 12'h111, 1, '{0, 1, 0, 1, 0, 0, 0, 0}, 4);
    add_seq(3'b011, 12'h113, 0, '{0, 0, 0, 1, 0, 0, 0, 1}, 8);
    add_seq(3'b111, 12'h102, 1, '{0, 0, 2, 0, 0, 2, 0, 0}, 6);
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      bus.i_req = vecs[i].req;
      bus.i_weight = vecs[i].w;
      bus.i_done = vecs[i].done;
      step("vec model");
      check("vec valid", bus.o_grant_valid, vecs[i].ev);
      check("vec grant", bus.o_grant, vecs[i].ev ? (1 << vecs[i].ei) : 0);
      if (vecs[i].ev) check("vec idx", bus.o_grant_idx, vecs[i].ei);
    end
    bus.i_done = 1'b0;
    do_reset();
    bus.i_weight = 12'h023;
    bus.i_req = 3'b011;
    step("forfeit");
    check("forfeit first idx", bus.o_grant_idx, 0);
    bus.i_done = 1'b1;
    step("forfeit");
    bus.i_done = 1'b0;
    bus.i_req = 3'b010;
    step("forfeit");
    check("forfeit switch valid", bus.o_grant_valid, 1);
    check("forfeit switch idx", bus.o_grant_idx, 1);
    bus.i_done = 1'b1;
    step("forfeit");
    bus.i_done = 1'b0;
    bus.i_req = 3'b011;
    for (int j = 0; j < 5; j++) begin
      step("forfeit");
      check("forfeit seq idx", bus.o_grant_idx, es[j]);
      bus.i_done = 1'b1;
      step("forfeit");
      bus.i_done = 1'b0;
    end
    step("hold");
    bus.i_req = '0;
    for (int j = 0; j < 10; j++) begin
      step("hold");
      check("hold valid", bus.o_grant_valid, 1);
    end
    bus.i_done = 1'b1;
    step("hold");
    check("hold release", bus.o_grant_valid, 0);
    hold_idx = m_idx;
    for (int j = 0; j < 3; j++) begin
      step("stray");
      check("stray valid", bus.o_grant_valid, 0);
      check("stray idx", bus.o_grant_idx, hold_idx);
    end
    bus.i_done = 1'b0;
    do_reset();
    bus.i_weight = 12'h011;
    bus.i_req = 3'b010;
    step("midrst");
    check("midrst grant idx", bus.o_grant_idx, 1);
    bus.i_req = 3'b011;
    @(posedge clk);
    model_edge();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("midrst valid", bus.o_grant_valid, 0);
    check("midrst grant", bus.o_grant, 0);
    @(negedge clk);
    rst = 1'b0;
    step("postrst");
    check("postrst first idx", bus.o_grant_idx, 0);
    check("postrst valid", bus.o_grant_valid, 1);
    do_reset();
    bus.i_weight = 12'hF2F;
    for (int c = 0; c < 600; c++) begin
      bus.i_req = N'($urandom_range(0, 7));
      bus.i_done = $urandom_range(0, 2) == 0;
      if (c % 25 == 0 && c != 0)
        for (int k = 0; k < N; k++)
          bus.i_weight[k*W +: W] = $urandom_range(0, 3) == 0 ? 4'd0 : W'($urandom_range(1, 15));
      step("random");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
